// File: rtl/mcb_ref_sched.sv
// Multi-rank refresh scheduler: tREFI interval timer with per-rank staggered
// ticks, per-rank postponed-refresh debt, and request/urgent/alert reporting
// toward the MCB command scheduler.
module mcb_ref_sched #(
    parameter int unsigned TREFI        = 1560,
    parameter int unsigned NRANK        = 2,
    parameter int unsigned RW           = 1,
    parameter int unsigned MAX_POSTPONE = 8,
    parameter int unsigned ALERT_LVL    = 4,
    parameter int unsigned CNT_W        = 4
) (
    input  logic                   mcb_clk,
    input  logic                   mcb_rst,
    input  logic                   mcb_sclr_n,
    input  logic                   i_ready,
    input  logic                   c_ready,
    input  logic                   c_ref,
    input  logic [RW-1:0]          c_ref_rank,
    output logic [NRANK-1:0]       r_ref_req,
    output logic [NRANK-1:0]       r_ref_urgent,
    output logic                   r_ref_alert,
    output logic [NRANK*CNT_W-1:0] r_ref_debt,
    output logic                   r_ref_ovf
);

    localparam int unsigned      STAG       = TREFI / NRANK;
    localparam int unsigned      TW         = (TREFI > 1) ? $clog2(TREFI) : 1;
    localparam logic [TW-1:0]    TIMER_LAST = TW'(TREFI - 1);
    localparam logic [CNT_W-1:0] DEBT_MAX   = CNT_W'(MAX_POSTPONE);
    localparam logic [CNT_W-1:0] DEBT_ALERT = CNT_W'(ALERT_LVL);

    logic [TW-1:0]                 timer;
    logic [NRANK-1:0][CNT_W-1:0]   debt;
    logic [NRANK-1:0]              tick;
    logic [NRANK-1:0]              retire;

    // Per-rank tick decode (staggered phases) and refresh-grant decode;
    // an out-of-range rank index simply matches no rank.
    always_comb begin
        tick   = '0;
        retire = '0;
        for (int unsigned k = 0; k < NRANK; k++) begin
            tick[k]   = i_ready && (timer == TW'(TREFI - 1 - k * STAG));
            retire[k] = i_ready && c_ref && (32'(c_ref_rank) == k);
        end
    end

    // Interval timer: free-running 0..TREFI-1 while init is complete.
    always_ff @(posedge mcb_clk or posedge mcb_rst) begin
        if (mcb_rst) begin
            timer <= '0;
        end else if (!mcb_sclr_n || !i_ready) begin
            timer <= '0;
        end else if (timer == TIMER_LAST) begin
            timer <= '0;
        end else begin
            timer <= timer + TW'(1);
        end
    end

    // Debt counters: tick adds, grant retires, a coincident pair cancels.
    always_ff @(posedge mcb_clk or posedge mcb_rst) begin
        if (mcb_rst) begin
            debt <= '0;
        end else if (!mcb_sclr_n || !i_ready) begin
            debt <= '0;
        end else begin
            for (int unsigned k = 0; k < NRANK; k++) begin
                if (tick[k] && !retire[k]) begin
                    if (debt[k] != DEBT_MAX) begin
                        debt[k] <= debt[k] + CNT_W'(1);
                    end
                end else if (retire[k] && !tick[k]) begin
                    if (debt[k] != '0) begin
                        debt[k] <= debt[k] - CNT_W'(1);
                    end
                end
            end
        end
    end

    // Sticky overflow: a lone tick landing on a rank already at the ceiling;
    // survives i_ready dropping, cleared only by reset or sync clear.
    always_ff @(posedge mcb_clk or posedge mcb_rst) begin
        if (mcb_rst) begin
            r_ref_ovf <= 1'b0;
        end else if (!mcb_sclr_n) begin
            r_ref_ovf <= 1'b0;
        end else if (i_ready) begin
            for (int unsigned k = 0; k < NRANK; k++) begin
                if (tick[k] && !retire[k] && (debt[k] == DEBT_MAX)) begin
                    r_ref_ovf <= 1'b1;
                end
            end
        end
    end

    // Status decode from the registered debt.
    always_comb begin
        r_ref_debt   = debt;
        r_ref_req    = '0;
        r_ref_urgent = '0;
        r_ref_alert  = 1'b0;
        for (int unsigned k = 0; k < NRANK; k++) begin
            r_ref_req[k]    = i_ready && c_ready && (debt[k] != '0);
            r_ref_urgent[k] = (debt[k] == DEBT_MAX);
            if (debt[k] >= DEBT_ALERT) begin
                r_ref_alert = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mcb_ref_sched.sv
// Bench for mcb_ref_sched: elapsed-time reference model of the staggered
// refresh debt, directed scenarios plus randomized grant traffic. A second,
// single-rank instance shares the inputs to exercise out-of-range ranks.
module tb_mcb_ref_sched;

    localparam int TREFI = 16;
    localparam int MAXP  = 8;
    localparam int ALVL  = 4;

    logic       clk = 1'b0;
    logic       mcb_rst = 1'b1;
    logic       mcb_sclr_n = 1'b1;
    logic       i_ready = 1'b0;
    logic       c_ready = 1'b0;
    logic       c_ref = 1'b0;
    logic [0:0] c_ref_rank = 1'b0;

    logic [1:0] r_ref_req, r_ref_urgent;
    logic       r_ref_alert, r_ref_ovf;
    logic [7:0] r_ref_debt;
    logic [0:0] d1_req, d1_urgent;
    logic       d1_alert, d1_ovf;
    logic [3:0] d1_debt;

    logic [21:0] obs;
    assign obs = {r_ref_req, r_ref_urgent, r_ref_alert, r_ref_debt, r_ref_ovf,
                  d1_debt, d1_ovf, d1_req, d1_urgent, d1_alert};

    int checks = 0;
    int failures = 0;

    // reference model state: elapsed ready cycles and per-rank debt
    int m_n;
    int m_debt[2];
    bit m_ovf;
    int m1_debt;
    bit m1_ovf;

    always #5 clk = ~clk;

    mcb_ref_sched #(.TREFI(16), .NRANK(2), .RW(1), .MAX_POSTPONE(8),
                    .ALERT_LVL(4), .CNT_W(4)) dut (
        .mcb_clk(clk), .mcb_rst(mcb_rst), .mcb_sclr_n(mcb_sclr_n),
        .i_ready(i_ready), .c_ready(c_ready), .c_ref(c_ref),
        .c_ref_rank(c_ref_rank), .r_ref_req(r_ref_req),
        .r_ref_urgent(r_ref_urgent), .r_ref_alert(r_ref_alert),
        .r_ref_debt(r_ref_debt), .r_ref_ovf(r_ref_ovf));

    mcb_ref_sched #(.TREFI(16), .NRANK(1), .RW(1), .MAX_POSTPONE(8),
                    .ALERT_LVL(4), .CNT_W(4)) dut1 (
        .mcb_clk(clk), .mcb_rst(mcb_rst), .mcb_sclr_n(mcb_sclr_n),
        .i_ready(i_ready), .c_ready(c_ready), .c_ref(c_ref),
        .c_ref_rank(c_ref_rank), .r_ref_req(d1_req),
        .r_ref_urgent(d1_urgent), .r_ref_alert(d1_alert),
        .r_ref_debt(d1_debt), .r_ref_ovf(d1_ovf));

    task automatic model_reset();
        m_n = 0; m_debt[0] = 0; m_debt[1] = 0; m_ovf = 0;
        m1_debt = 0; m1_ovf = 0;
    endtask

    function automatic int next_debt(int d, bit t, bit r);
        if (t && !r) return (d < MAXP) ? d + 1 : d;
        if (r && !t) return (d > 0) ? d - 1 : 0;
        return d;
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_update();
        bit t, r;
        if (mcb_rst || !mcb_sclr_n) begin
            model_reset();
        end else if (!i_ready) begin
            m_n = 0; m_debt[0] = 0; m_debt[1] = 0; m1_debt = 0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                t = (m_n % TREFI) == (TREFI - 1 - k * (TREFI / 2));
                r = c_ref && (int'(c_ref_rank) == k);
                if (t && !r && m_debt[k] == MAXP) m_ovf = 1;
                m_debt[k] = next_debt(m_debt[k], t, r);
            end
            t = (m_n % TREFI) == (TREFI - 1);
            r = c_ref && (c_ref_rank == 1'b0);
            if (t && !r && m1_debt == MAXP) m1_ovf = 1;
            m1_debt = next_debt(m1_debt, t, r);
            m_n++;
        end
    endtask

    function automatic logic [21:0] model_out();
        logic [1:0] req, urg;
        logic [7:0] dbt;
        logic al;
        al = 1'b0;
        for (int k = 0; k < 2; k++) begin
            req[k] = i_ready && c_ready && (m_debt[k] != 0);
            urg[k] = (m_debt[k] == MAXP);
            dbt[k*4 +: 4] = 4'(m_debt[k]);
            if (m_debt[k] >= ALVL) al = 1'b1;
        end
        return {req, urg, al, dbt, m_ovf, 4'(m1_debt), m1_ovf,
                i_ready && c_ready && (m1_debt != 0), m1_debt == MAXP,
                m1_debt >= ALVL};
    endfunction

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        #1;
        checks++;
        if (obs !== 22'h0) begin
            failures++;
            $display("FAIL reset_async dut=%h want=%h", obs, 22'h0);
        end
        repeat (3) step();
        mcb_rst = 1'b0;
        step();
        checks++;
        if (obs !== model_out()) begin
            failures++;
            $display("FAIL reset_release dut=%h model=%h", obs, model_out());
        end
    endtask

    task automatic test_stagger();
        i_ready = 1'b1;
        c_ready = 1'b1;
        for (int c = 0; c <= 16; c++) begin
            checks++;
            if (obs !== model_out()) begin
                failures++;
                $display("FAIL stagger cyc=%0d dut=%h model=%h", c, obs, model_out());
            end
            if (c == 7 || c == 8 || c == 16) begin
                checks++;
                if (r_ref_req !== ((c == 7) ? 2'b00 : (c == 8) ? 2'b10 : 2'b11)) begin
                    failures++;
                    $display("FAIL stagger_req cyc=%0d req=%b", c, r_ref_req);
                end
            end
            if (c < 16) step();
        end
    endtask

    task automatic test_retire();
        repeat (4) step();
        c_ref = 1'b1;
        c_ref_rank = 1'b0;
        step();
        c_ref = 1'b0;
        checks++;
        if (obs !== model_out() || r_ref_req !== 2'b10 || r_ref_debt !== 8'h10) begin
            failures++;
            $display("FAIL retire dut=%h model=%h req=%b debt=%h want req=10 debt=10",
                     obs, model_out(), r_ref_req, r_ref_debt);
        end
    endtask

    task automatic test_postpone();
        for (int i = 0; i < 200; i++) begin
            step();
            checks++;
            if (obs !== model_out()) begin
                failures++;
                $display("FAIL postpone cyc=%0d dut=%h model=%h", m_n, obs, model_out());
            end
            if (m_ovf) break;
        end
        checks++;
        if (r_ref_ovf !== 1'b1 || r_ref_debt !== 8'h87 || r_ref_urgent !== 2'b10 ||
            r_ref_alert !== 1'b1) begin
            failures++;
            $display("FAIL postpone_ovf ovf=%b debt=%h urg=%b alert=%b want 1/87/10/1",
                     r_ref_ovf, r_ref_debt, r_ref_urgent, r_ref_alert);
        end
        i_ready = 1'b0;
        step();
        step();
        i_ready = 1'b1;
        step();
        checks++;
        if (obs !== model_out() || r_ref_ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_sticky dut=%h model=%h ovf=%b want 1", obs, model_out(), r_ref_ovf);
        end
        mcb_sclr_n = 1'b0;
        step();
        mcb_sclr_n = 1'b1;
        checks++;
        if (r_ref_ovf !== 1'b0 || obs !== model_out()) begin
            failures++;
            $display("FAIL sclr_ovf ovf=%b dut=%h model=%h", r_ref_ovf, obs, model_out());
        end
    endtask

    task automatic test_collision();
        for (int c = 0; c <= 143; c++) begin
            c_ref = (c == 100 || c == 143);
            c_ref_rank = (c == 100) ? 1'b1 : 1'b0;
            step();
            checks++;
            if (obs !== model_out()) begin
                failures++;
                $display("FAIL collision cyc=%0d dut=%h model=%h", c + 1, obs, model_out());
            end
        end
        c_ref = 1'b0;
        checks++;
        if (r_ref_debt !== 8'h88 || r_ref_ovf !== 1'b0) begin
            failures++;
            $display("FAIL collision_end debt=%h ovf=%b want 88/0", r_ref_debt, r_ref_ovf);
        end
    endtask

    task automatic test_masking();
        c_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs !== model_out() || r_ref_req !== 2'b00 || r_ref_urgent !== 2'b11 ||
                r_ref_alert !== 1'b1) begin
                failures++;
                $display("FAIL mask cyc=%0d req=%b urg=%b alert=%b want 00/11/1",
                         i, r_ref_req, r_ref_urgent, r_ref_alert);
            end
        end
        c_ready = 1'b1;
        step();
        checks++;
        if (r_ref_req !== 2'b11) begin
            failures++;
            $display("FAIL unmask req=%b want 11", r_ref_req);
        end
        i_ready = 1'b0;
        step();
        i_ready = 1'b1;
        c_ref = 1'b1;
        c_ref_rank = 1'b0;
        step();
        c_ref = 1'b0;
        checks++;
        if (obs !== model_out() || r_ref_debt !== 8'h00) begin
            failures++;
            $display("FAIL ref_at_zero debt=%h want 00 dut=%h model=%h",
                     r_ref_debt, obs, model_out());
        end
        repeat (15) step();
        c_ref = 1'b1;
        c_ref_rank = 1'b1;
        step();
        c_ref = 1'b0;
        checks++;
        if (obs !== model_out() || d1_debt !== 4'd1 || r_ref_debt !== 8'h01) begin
            failures++;
            $display("FAIL rank_range d1_debt=%0d debt=%h want 1/01 dut=%h model=%h",
                     d1_debt, r_ref_debt, obs, model_out());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            c_ready = ($urandom % 4) != 0;
            c_ref = ($urandom % 3) == 0;
            c_ref_rank = 1'($urandom % 2);
            i_ready = ($urandom % 200) != 0;
            step();
            checks++;
            if (obs !== model_out()) begin
                failures++;
                $display("FAIL random i=%0d dut=%h model=%h", i, obs, model_out());
            end
        end
        c_ref = 1'b0;
        c_ready = 1'b1;
        i_ready = 1'b1;
    endtask

    task automatic test_reset_clear();
        i_ready = 1'b0;
        step();
        i_ready = 1'b1;
        repeat (48) step();
        checks++;
        if (r_ref_debt !== 8'h33) begin
            failures++;
            $display("FAIL pre_rst debt=%h want 33", r_ref_debt);
        end
        #2;
        mcb_rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (obs !== 22'h0) begin
            failures++;
            $display("FAIL rst_mid dut=%h want 0", obs);
        end
        step();
        mcb_rst = 1'b0;
        for (int c = 0; c <= 8; c++) begin
            checks++;
            if (obs !== model_out() || r_ref_req !== ((c == 8) ? 2'b10 : 2'b00)) begin
                failures++;
                $display("FAIL rst_restart cyc=%0d dut=%h model=%h", c, obs, model_out());
            end
            if (c < 8) step();
        end
        repeat (12) step();
        mcb_sclr_n = 1'b0;
        #1;
        checks++;
        if (r_ref_debt !== 8'h11) begin
            failures++;
            $display("FAIL sclr_sync debt=%h want 11 before edge", r_ref_debt);
        end
        step();
        mcb_sclr_n = 1'b1;
        checks++;
        if (obs !== 22'h0) begin
            failures++;
            $display("FAIL sclr_clear dut=%h want 0", obs);
        end
        for (int c = 0; c <= 8; c++) begin
            checks++;
            if (obs !== model_out() || r_ref_req !== ((c == 8) ? 2'b10 : 2'b00)) begin
                failures++;
                $display("FAIL sclr_restart cyc=%0d dut=%h model=%h", c, obs, model_out());
            end
            if (c < 8) step();
        end
    endtask

    initial begin
        test_reset();
        test_stagger();
        test_retire();
        test_postpone();
        test_collision();
        test_masking();
        test_random();
        test_reset_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
